ysyx_23060184_data_xbar: RTL and testbench

Address-decoding 1-master/2-slave AXI4-Lite crossbar on the data-memory path, directly downstream of the memory stage's data master port (`d_*`). It routes each load/store to the SRAM slave or the UART slave by address and answers unmapped addresses locally with DECERR. Exactly one transaction is in flight at a time, and all master-side request signals are registered, so slaves see a stable buffered request.

---
 rtl/ysyx_23060184_data_xbar.sv | 239 +++++++++++++++++++++++
 tb/tb_ysyx_23060184_data_xbar.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_data_xbar.sv
// Data-path AXI4-Lite crossbar: one master, SRAM and UART slaves, local DECERR.
// One transaction at a time; the request is latched on acceptance and replayed to the slave.
module ysyx_23060184_data_xbar #(
  parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
  parameter logic [31:0] SRAM_SIZE = 32'h0800_0000,
  parameter logic [31:0] UART_BASE = 32'ha000_03f8,
  parameter logic [31:0] UART_SIZE = 32'h0000_0008
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] m_araddr,
  input  logic        m_arvalid,
  output logic        m_arready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic        m_rvalid,
  input  logic        m_rready,
  input  logic [31:0] m_awaddr,
  input  logic        m_awvalid,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wvalid,
  output logic        m_awready,
  output logic        m_wready,
  output logic [1:0]  m_bresp,
  output logic        m_bvalid,
  input  logic        m_bready,
  output logic [31:0] sram_araddr,
  output logic        sram_arvalid,
  input  logic        sram_arready,
  input  logic [31:0] sram_rdata,
  input  logic [1:0]  sram_rresp,
  input  logic        sram_rvalid,
  output logic        sram_rready,
  output logic [31:0] sram_awaddr,
  output logic        sram_awvalid,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_wstrb,
  output logic        sram_wvalid,
  input  logic        sram_awready,
  input  logic        sram_wready,
  input  logic [1:0]  sram_bresp,
  input  logic        sram_bvalid,
  output logic        sram_bready,
  output logic [31:0] uart_araddr,
  output logic        uart_arvalid,
  input  logic        uart_arready,
  input  logic [31:0] uart_rdata,
  input  logic [1:0]  uart_rresp,
  input  logic        uart_rvalid,
  output logic        uart_rready,
  output logic [31:0] uart_awaddr,
  output logic        uart_awvalid,
  output logic [31:0] uart_wdata,
  output logic [3:0]  uart_wstrb,
  output logic        uart_wvalid,
  input  logic        uart_awready,
  input  logic        uart_wready,
  input  logic [1:0]  uart_bresp,
  input  logic        uart_bvalid,
  output logic        uart_bready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RA    = 3'd1;
  localparam logic [2:0] S_RD    = 3'd2;
  localparam logic [2:0] S_WA    = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_ERR_R = 3'd5;
  localparam logic [2:0] S_ERR_B = 3'd6;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_SRAM = 2'd1;
  localparam logic [1:0] SEL_UART = 2'd2;
  localparam logic [1:0] SEL_ERR  = 2'd3;

  logic [2:0]  state;
  logic [1:0]  sel;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        aw_done;
  logic        w_done;

  // 33-bit compares keep a window that ends exactly at 2^32 from wrapping to zero.
  function automatic logic [1:0] decode(input logic [31:0] a);
    logic [32:0] a33;
    a33 = {1'b0, a};
    if (a33 >= {1'b0, SRAM_BASE} && a33 < ({1'b0, SRAM_BASE} + {1'b0, SRAM_SIZE}))
      decode = SEL_SRAM;
    else if (a33 >= {1'b0, UART_BASE} && a33 < ({1'b0, UART_BASE} + {1'b0, UART_SIZE}))
      decode = SEL_UART;
    else
      decode = SEL_ERR;
  endfunction

  logic [1:0] rd_sel;
  logic [1:0] wr_sel;
  logic       rd_accept;
  logic       wr_accept;
  logic       is_sram;
  logic       is_uart;

  assign rd_sel    = decode(m_araddr);
  assign wr_sel    = decode(m_awaddr);
  assign rd_accept = (state == S_IDLE) & m_arvalid;
  assign wr_accept = (state == S_IDLE) & m_awvalid & m_wvalid & ~m_arvalid;
  assign m_arready = rd_accept;
  assign m_awready = wr_accept;
  assign m_wready  = wr_accept;
  assign is_sram   = (sel == SEL_SRAM);
  assign is_uart   = (sel == SEL_UART);

  logic        s_arready;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_awready;
  logic        s_wready;
  logic        s_bvalid;
  logic [1:0]  s_bresp;

  assign s_arready = is_sram ? sram_arready : uart_arready;
  assign s_rvalid  = is_sram ? sram_rvalid  : uart_rvalid;
  assign s_rdata   = is_sram ? sram_rdata   : uart_rdata;
  assign s_rresp   = is_sram ? sram_rresp   : uart_rresp;
  assign s_awready = is_sram ? sram_awready : uart_awready;
  assign s_wready  = is_sram ? sram_wready  : uart_wready;
  assign s_bvalid  = is_sram ? sram_bvalid  : uart_bvalid;
  assign s_bresp   = is_sram ? sram_bresp   : uart_bresp;

  logic ar_v, r_rdy, aw_v, w_v, b_rdy;
  logic aw_hs, w_hs;

  always_comb begin
    m_rvalid = 1'b0;
    m_rdata  = 32'h0;
    m_rresp  = 2'b00;
    m_bvalid = 1'b0;
    m_bresp  = 2'b00;
    ar_v     = 1'b0;
    r_rdy    = 1'b0;
    aw_v     = 1'b0;
    w_v      = 1'b0;
    b_rdy    = 1'b0;
    case (state)
      S_RA: ar_v = 1'b1;
      S_RD: begin
        m_rvalid = s_rvalid;
        m_rdata  = s_rdata;
        m_rresp  = s_rresp;
        r_rdy    = m_rready;
      end
      S_WA: begin
        aw_v = ~aw_done;
        w_v  = ~w_done;
      end
      S_WB: begin
        m_bvalid = s_bvalid;
        m_bresp  = s_bresp;
        b_rdy    = m_bready;
      end
      S_ERR_R: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
      end
      S_ERR_B: begin
        m_bvalid = 1'b1;
        m_bresp  = 2'b11;
      end
      default: ;
    endcase
  end

  assign aw_hs = aw_v & s_awready;
  assign w_hs  = w_v & s_wready;

  assign sram_araddr  = addr;
  assign uart_araddr  = addr;
  assign sram_awaddr  = addr;
  assign uart_awaddr  = addr;
  assign sram_wdata   = wdata;
  assign uart_wdata   = wdata;
  assign sram_wstrb   = wstrb;
  assign uart_wstrb   = wstrb;
  assign sram_arvalid = ar_v  & is_sram;
  assign uart_arvalid = ar_v  & is_uart;
  assign sram_rready  = r_rdy & is_sram;
  assign uart_rready  = r_rdy & is_uart;
  assign sram_awvalid = aw_v  & is_sram;
  assign uart_awvalid = aw_v  & is_uart;
  assign sram_wvalid  = w_v   & is_sram;
  assign uart_wvalid  = w_v   & is_uart;
  assign sram_bready  = b_rdy & is_sram;
  assign uart_bready  = b_rdy & is_uart;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      sel     <= SEL_NONE;
      addr    <= 32'h0;
      wdata   <= 32'h0;
      wstrb   <= 4'h0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_accept) begin
            addr  <= m_araddr;
            sel   <= rd_sel;
            state <= (rd_sel == SEL_ERR) ? S_ERR_R : S_RA;
          end else if (wr_accept) begin
            addr    <= m_awaddr;
            wdata   <= m_wdata;
            wstrb   <= m_wstrb;
            sel     <= wr_sel;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= (wr_sel == SEL_ERR) ? S_ERR_B : S_WA;
          end
        end
        S_RA: if (s_arready) state <= S_RD;
        S_RD: if (s_rvalid & m_rready) state <= S_IDLE;
        S_WA: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          // both halves may finish in the same cycle, so count this cycle's handshakes
          if ((aw_done | aw_hs) & (w_done | w_hs)) state <= S_WB;
        end
        S_WB:    if (s_bvalid & m_bready) state <= S_IDLE;
        S_ERR_R: if (m_rready) state <= S_IDLE;
        S_ERR_B: if (m_bready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_data_xbar.sv
// Bench for the data crossbar: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level reference model.
module tb_ysyx_23060184_data_xbar;
  logic        clk;
  logic        rstn;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_awready;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] sram_araddr, uart_araddr;
  logic        sram_arvalid, uart_arvalid;
  logic        sram_arready, uart_arready;
  logic [31:0] sram_rdata, uart_rdata;
  logic [1:0]  sram_rresp, uart_rresp;
  logic        sram_rvalid, uart_rvalid;
  logic        sram_rready, uart_rready;
  logic [31:0] sram_awaddr, uart_awaddr;
  logic        sram_awvalid, uart_awvalid;
  logic [31:0] sram_wdata, uart_wdata;
  logic [3:0]  sram_wstrb, uart_wstrb;
  logic        sram_wvalid, uart_wvalid;
  logic        sram_awready, uart_awready;
  logic        sram_wready, uart_wready;
  logic [1:0]  sram_bresp, uart_bresp;
  logic        sram_bvalid, uart_bvalid;
  logic        sram_bready, uart_bready;

  ysyx_23060184_data_xbar dut (
    .clk(clk), .rstn(rstn),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wvalid(m_wvalid), .m_awready(m_awready), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .sram_araddr(sram_araddr), .sram_arvalid(sram_arvalid), .sram_arready(sram_arready),
    .sram_rdata(sram_rdata), .sram_rresp(sram_rresp), .sram_rvalid(sram_rvalid),
    .sram_rready(sram_rready), .sram_awaddr(sram_awaddr), .sram_awvalid(sram_awvalid),
    .sram_wdata(sram_wdata), .sram_wstrb(sram_wstrb), .sram_wvalid(sram_wvalid),
    .sram_awready(sram_awready), .sram_wready(sram_wready), .sram_bresp(sram_bresp),
    .sram_bvalid(sram_bvalid), .sram_bready(sram_bready),
    .uart_araddr(uart_araddr), .uart_arvalid(uart_arvalid), .uart_arready(uart_arready),
    .uart_rdata(uart_rdata), .uart_rresp(uart_rresp), .uart_rvalid(uart_rvalid),
    .uart_rready(uart_rready), .uart_awaddr(uart_awaddr), .uart_awvalid(uart_awvalid),
    .uart_wdata(uart_wdata), .uart_wstrb(uart_wstrb), .uart_wvalid(uart_wvalid),
    .uart_awready(uart_awready), .uart_wready(uart_wready), .uart_bresp(uart_bresp),
    .uart_bvalid(uart_bvalid), .uart_bready(uart_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %b expected %b at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: target 0 = SRAM, 1 = UART, 2 = decode error.
  function automatic int decode(input logic [31:0] a);
    longint ua;
    ua = {32'h0, a};
    if (ua >= 64'h8000_0000 && ua < 64'h8000_0000 + 64'h0800_0000) return 0;
    if (ua >= 64'ha000_03f8 && ua < 64'ha000_03f8 + 64'h8) return 1;
    return 2;
  endfunction

  function automatic logic s_arready(int t); return t == 0 ? sram_arready : uart_arready; endfunction
  function automatic logic s_awready(int t); return t == 0 ? sram_awready : uart_awready; endfunction
  function automatic logic s_wready(int t);  return t == 0 ? sram_wready  : uart_wready;  endfunction
  function automatic logic s_rvalid(int t);  return t == 0 ? sram_rvalid  : uart_rvalid;  endfunction
  function automatic logic s_bvalid(int t);  return t == 0 ? sram_bvalid  : uart_bvalid;  endfunction
  function automatic logic [31:0] s_rdata(int t); return t == 0 ? sram_rdata : uart_rdata; endfunction
  function automatic logic [1:0] s_rresp(int t);  return t == 0 ? sram_rresp : uart_rresp; endfunction
  function automatic logic [1:0] s_bresp(int t);  return t == 0 ? sram_bresp : uart_bresp; endfunction

  // One outstanding transaction: is it a read, which target, and which request halves
  // the slave has yet to take. With nothing pending the transaction is in its response phase.
  bit          busy = 1'b0;
  bit          is_rd = 1'b0;
  bit          pend_a = 1'b0;
  bit          pend_w = 1'b0;
  int          tgt = 0;
  logic [31:0] ma = 32'h0;
  logic [31:0] md = 32'h0;
  logic [3:0]  ms = 4'h0;

  always @(posedge clk) begin
    if (!rstn) begin
      busy <= 1'b0;
      pend_a <= 1'b0;
      pend_w <= 1'b0;
    end else if (!busy) begin
      if (m_arvalid) begin
        busy <= 1'b1; is_rd <= 1'b1; tgt <= decode(m_araddr); ma <= m_araddr;
        pend_a <= (decode(m_araddr) != 2); pend_w <= 1'b0;
      end else if (m_awvalid && m_wvalid) begin
        busy <= 1'b1; is_rd <= 1'b0; tgt <= decode(m_awaddr); ma <= m_awaddr;
        md <= m_wdata; ms <= m_wstrb;
        pend_a <= (decode(m_awaddr) != 2); pend_w <= (decode(m_awaddr) != 2);
      end
    end else if (is_rd) begin
      if (pend_a) begin
        if (s_arready(tgt)) pend_a <= 1'b0;
      end else if ((tgt == 2 || s_rvalid(tgt)) && m_rready) busy <= 1'b0;
    end else begin
      if (pend_a || pend_w) begin
        if (pend_a && s_awready(tgt)) pend_a <= 1'b0;
        if (pend_w && s_wready(tgt))  pend_w <= 1'b0;
      end else if ((tgt == 2 || s_bvalid(tgt)) && m_bready) busy <= 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    logic on, rph, wph;
    if (chk_en) begin
      chk1("m_arready", m_arready, !busy && m_arvalid);
      chk1("m_awready", m_awready, !busy && m_awvalid && m_wvalid && !m_arvalid);
      chk1("m_wready",  m_wready,  !busy && m_awvalid && m_wvalid && !m_arvalid);
      rph = busy && is_rd && !pend_a;
      wph = busy && !is_rd && !pend_a && !pend_w;
      chk1("m_rvalid", m_rvalid, rph && (tgt == 2 || s_rvalid(tgt)));
      chk32("m_rdata", m_rdata, (rph && tgt != 2) ? s_rdata(tgt) : 32'h0);
      chk32("m_rresp", {30'h0, m_rresp}, {30'h0, rph ? (tgt == 2 ? 2'b11 : s_rresp(tgt)) : 2'b00});
      chk1("m_bvalid", m_bvalid, wph && (tgt == 2 || s_bvalid(tgt)));
      chk32("m_bresp", {30'h0, m_bresp}, {30'h0, wph ? (tgt == 2 ? 2'b11 : s_bresp(tgt)) : 2'b00});
      for (int t = 0; t < 2; t++) begin
        on = busy && tgt == t;
        chk1(t == 0 ? "sram_arvalid" : "uart_arvalid", t == 0 ? sram_arvalid : uart_arvalid,
             on && is_rd && pend_a);
        chk1(t == 0 ? "sram_rready" : "uart_rready", t == 0 ? sram_rready : uart_rready,
             on && rph && m_rready);
        chk1(t == 0 ? "sram_awvalid" : "uart_awvalid", t == 0 ? sram_awvalid : uart_awvalid,
             on && !is_rd && pend_a);
        chk1(t == 0 ? "sram_wvalid" : "uart_wvalid", t == 0 ? sram_wvalid : uart_wvalid,
             on && !is_rd && pend_w);
        chk1(t == 0 ? "sram_bready" : "uart_bready", t == 0 ? sram_bready : uart_bready,
             on && wph && m_bready);
        if (on && is_rd && pend_a)
          chk32("araddr", t == 0 ? sram_araddr : uart_araddr, ma);
        if (on && !is_rd && pend_a)
          chk32("awaddr", t == 0 ? sram_awaddr : uart_awaddr, ma);
        if (on && !is_rd && pend_w) begin
          chk32("wdata", t == 0 ? sram_wdata : uart_wdata, md);
          chk32("wstrb", {28'h0, t == 0 ? sram_wstrb : uart_wstrb}, {28'h0, ms});
        end
      end
    end
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask

  task automatic idle_inputs();
    m_arvalid = 0; m_araddr = 0; m_rready = 0;
    m_awvalid = 0; m_awaddr = 0; m_wvalid = 0; m_wdata = 0; m_wstrb = 0; m_bready = 0;
    sram_arready = 0; sram_rvalid = 0; sram_rdata = 0; sram_rresp = 0;
    sram_awready = 0; sram_wready = 0; sram_bvalid = 0; sram_bresp = 0;
    uart_arready = 0; uart_rvalid = 0; uart_rdata = 0; uart_rresp = 0;
    uart_awready = 0; uart_wready = 0; uart_bvalid = 0; uart_bresp = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 11))
      0: return 32'h8000_0000;
      1: return 32'h8000_0010;
      2: return 32'h87ff_fffc;
      3: return 32'h8800_0000;
      4: return 32'h7fff_fffc;
      5: return 32'ha000_03f8;
      6: return 32'ha000_03ff;
      7: return 32'ha000_0400;
      8: return 32'ha000_03f7;
      9: return 32'h1000_0000;
      10: return 32'hffff_fffc;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle_inputs();
    rstn = 0;
    cyc(); cyc();
    smp();
    chk1("rst_sram_arvalid", sram_arvalid, 1'b0);
    chk1("rst_m_rvalid", m_rvalid, 1'b0);
    chk1("rst_m_bvalid", m_bvalid, 1'b0);
    chk32("rst_sram_araddr", sram_araddr, 32'h0);
    chk32("rst_uart_wdata", uart_wdata, 32'h0);
    chk_en = 1'b1;
    cyc(); rstn = 1;

    // SRAM read
    cyc(); m_arvalid = 1; m_araddr = 32'h8000_0010;
    smp(); chk1("rd_arready_c0", m_arready, 1'b1);
    cyc(); idle_inputs(); sram_arready = 1;
    smp(); chk1("rd_sram_arvalid_c1", sram_arvalid, 1'b1);
    chk32("rd_sram_araddr", sram_araddr, 32'h8000_0010);
    chk1("rd_uart_arvalid", uart_arvalid, 1'b0);
    cyc(); sram_arready = 0; sram_rvalid = 1; sram_rdata = 32'hdead_beef; m_rready = 1;
    smp(); chk1("rd_m_rvalid_c2", m_rvalid, 1'b1);
    chk32("rd_m_rdata", m_rdata, 32'hdead_beef);
    chk32("rd_m_rresp", {30'h0, m_rresp}, 32'h0);
    chk1("rd_sram_arvalid_c2", sram_arvalid, 1'b0);
    cyc(); idle_inputs();
    smp(); chk1("rd_m_rvalid_c3", m_rvalid, 1'b0);

    // UART write, AW and W accepted in different cycles
    cyc(); m_awvalid = 1; m_wvalid = 1; m_awaddr = 32'ha000_03f8; m_wdata = 32'h41; m_wstrb = 4'b0001;
    smp(); chk1("wr_awready_c0", m_awready, 1'b1); chk1("wr_wready_c0", m_wready, 1'b1);
    cyc(); idle_inputs(); uart_awready = 1;
    smp(); chk1("wr_awvalid_c1", uart_awvalid, 1'b1); chk32("wr_awaddr", uart_awaddr, 32'ha000_03f8);
    cyc(); uart_awready = 0;
    smp(); chk1("wr_awvalid_c2", uart_awvalid, 1'b0); chk1("wr_wvalid_c2", uart_wvalid, 1'b1);
    cyc(); uart_wready = 1;
    smp(); chk1("wr_wvalid_c3", uart_wvalid, 1'b1); chk32("wr_wdata", uart_wdata, 32'h41);
    chk32("wr_wstrb", {28'h0, uart_wstrb}, 32'h1);
    cyc(); uart_wready = 0;
    smp(); chk1("wr_wvalid_c4", uart_wvalid, 1'b0); chk1("wr_bvalid_c4", m_bvalid, 1'b0);
    cyc(); uart_bvalid = 1; m_bready = 1;
    smp(); chk1("wr_m_bvalid", m_bvalid, 1'b1); chk32("wr_m_bresp", {30'h0, m_bresp}, 32'h0);
    chk1("wr_uart_bready", uart_bready, 1'b1);
    cyc(); idle_inputs();
    smp(); chk1("wr_m_bvalid_done", m_bvalid, 1'b0);

    // unmapped read answered locally
    cyc(); m_arvalid = 1; m_araddr = 32'h1000_0000;
    smp();
    cyc(); idle_inputs(); m_rready = 1;
    smp(); chk1("err_rvalid", m_rvalid, 1'b1); chk32("err_rresp", {30'h0, m_rresp}, 32'h3);
    chk32("err_rdata", m_rdata, 32'h0);
    chk1("err_sram_arvalid", sram_arvalid, 1'b0); chk1("err_uart_arvalid", uart_arvalid, 1'b0);
    cyc(); idle_inputs();
    smp(); chk1("err_rvalid_done", m_rvalid, 1'b0);

    // simultaneous read and write: read wins
    cyc(); m_arvalid = 1; m_araddr = 32'h8000_0000;
    m_awvalid = 1; m_wvalid = 1; m_awaddr = 32'h8000_0004; m_wdata = 32'h1234_5678; m_wstrb = 4'hf;
    smp(); chk1("sim_arready", m_arready, 1'b1); chk1("sim_awready_c0", m_awready, 1'b0);
    cyc(); m_arvalid = 0; sram_arready = 1;
    smp(); chk1("sim_awready_c1", m_awready, 1'b0);
    cyc(); sram_arready = 0; sram_rvalid = 1; sram_rdata = 32'hcafe_0001; m_rready = 1;
    smp(); chk1("sim_rvalid", m_rvalid, 1'b1); chk1("sim_awready_c2", m_awready, 1'b0);
    cyc(); sram_rvalid = 0; m_rready = 0;
    smp(); chk1("sim_awready_c3", m_awready, 1'b1);
    cyc(); m_awvalid = 0; m_wvalid = 0; sram_awready = 1; sram_wready = 1;
    smp(); chk1("sim_awvalid", sram_awvalid, 1'b1); chk32("sim_awaddr", sram_awaddr, 32'h8000_0004);
    chk32("sim_wdata", sram_wdata, 32'h1234_5678);
    cyc(); sram_awready = 0; sram_wready = 0; sram_bvalid = 1; m_bready = 1;
    smp(); chk1("sim_bvalid", m_bvalid, 1'b1);
    cyc(); idle_inputs();

    // response stall with m_rready low
    cyc(); m_arvalid = 1; m_araddr = 32'h8000_0020;
    cyc(); idle_inputs(); sram_arready = 1;
    cyc(); sram_arready = 0; sram_rvalid = 1; sram_rdata = 32'h5a5a_1234;
    for (int i = 0; i < 5; i++) begin
      smp(); chk1("stall_rvalid", m_rvalid, 1'b1); chk32("stall_rdata", m_rdata, 32'h5a5a_1234);
      chk1("stall_arready", m_arready, 1'b0);
      cyc();
    end
    m_rready = 1;
    smp(); chk1("stall_release", sram_rready, 1'b1);
    cyc(); idle_inputs(); m_arvalid = 1; m_araddr = 32'h1000_0000;
    smp(); chk1("stall_idle", m_arready, 1'b1); chk1("stall_rvalid_off", m_rvalid, 1'b0);
    cyc(); idle_inputs(); m_rready = 1;
    cyc(); idle_inputs();

    // reset in the middle of a write
    cyc(); m_awvalid = 1; m_wvalid = 1; m_awaddr = 32'h8000_0100; m_wdata = 32'h9; m_wstrb = 4'h3;
    cyc(); idle_inputs();
    smp(); chk1("rstwa_awvalid", sram_awvalid, 1'b1);
    cyc(); rstn = 0;
    cyc(); rstn = 1; sram_bvalid = 1; m_bready = 0;
    smp(); chk1("rstwa_awvalid_after", sram_awvalid, 1'b0); chk1("rstwa_wvalid_after", sram_wvalid, 1'b0);
    chk1("rstwa_bvalid", m_bvalid, 1'b0);
    cyc(); sram_bvalid = 0; m_arvalid = 1; m_araddr = 32'h8000_0008;
    smp(); chk1("rstwa_arready", m_arready, 1'b1);
    cyc(); idle_inputs(); sram_arready = 1;
    cyc(); sram_arready = 0; sram_rvalid = 1; sram_rdata = 32'h77; m_rready = 1;
    smp(); chk1("rstwa_rvalid", m_rvalid, 1'b1); chk32("rstwa_rdata", m_rdata, 32'h77);
    cyc(); idle_inputs();

    // random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rstn = ($urandom_range(0, 299) != 0);
      m_arvalid = ($urandom_range(0, 3) == 0); m_araddr = pick_addr();
      m_awvalid = ($urandom_range(0, 2) != 0); m_wvalid = ($urandom_range(0, 2) != 0);
      m_awaddr = pick_addr(); m_wdata = $urandom; m_wstrb = 4'($urandom);
      m_rready = ($urandom_range(0, 3) != 0); m_bready = ($urandom_range(0, 3) != 0);
      sram_arready = 1'($urandom); sram_awready = 1'($urandom); sram_wready = 1'($urandom);
      sram_rvalid = 1'($urandom); sram_rdata = $urandom; sram_rresp = 2'($urandom);
      sram_bvalid = 1'($urandom); sram_bresp = 2'($urandom);
      uart_arready = 1'($urandom); uart_awready = 1'($urandom); uart_wready = 1'($urandom);
      uart_rvalid = 1'($urandom); uart_rdata = $urandom; uart_rresp = 2'($urandom);
      uart_bvalid = 1'($urandom); uart_bresp = 2'($urandom);
    end
    cyc(); idle_inputs();
    smp();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
